// File: rtl/klp32_lsu.sv
// klp32_lsu: single-outstanding RISC-V load/store unit between a core and a simple req/gnt memory port.
// Define KLP32_LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of rounding them down.
module klp32_lsu #(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_done,
  output logic              o_err,
  output logic [XLEN-1:0]   o_rdata,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [XLEN/8-1:0] o_mem_be,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Shift the addressed lanes down to bit 0, then sign/zero extend by access size.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic [2:0]       f3);
    logic [XLEN-1:0] s;
    s = word >> {off, 3'b000};
    case (f3)
      3'b000:  load_extend = XLEN'($signed(s[7:0]));
      3'b001:  load_extend = XLEN'($signed(s[15:0]));
      3'b010:  load_extend = XLEN'($signed(s[31:0]));
      3'b100:  load_extend = XLEN'(s[7:0]);
      3'b101:  load_extend = XLEN'(s[15:0]);
      3'b110:  load_extend = XLEN'(s[31:0]);
      default: load_extend = s;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic              ready_q, ready_d, done_q, done_d, err_q, err_d, req_q, req_d;
  logic [XLEN-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [NB-1:0]     be_q, be_d;

  logic [OFF_W-1:0]  off_s, low_s, aoff_s;
  logic [NB-1:0]     size_be_s;
  logic              illegal_s, trap_s, to_hit_s;

  // Decode size, legality and lane offset of the incoming request.
  always_comb begin
    case (i_funct3[1:0])
      2'b00:   begin low_s = OFF_W'(0); size_be_s = NB'(8'h01); end
      2'b01:   begin low_s = OFF_W'(1); size_be_s = NB'(8'h03); end
      2'b10:   begin low_s = OFF_W'(3); size_be_s = NB'(8'h0F); end
      default: begin low_s = OFF_W'(7); size_be_s = NB'(8'hFF); end
    endcase
    off_s     = i_addr[OFF_W-1:0];
    aoff_s    = off_s & ~low_s;
    illegal_s = (i_funct3 == 3'b111) || (i_we && i_funct3[2]) ||
                ((XLEN == 32) && ((i_funct3 == 3'b011) || (i_funct3 == 3'b110)));
`ifdef KLP32_LSU_MISALIGN_TRAP_EN
    trap_s    = |(off_s & low_s);
`else
    trap_s    = 1'b0;
`endif
  end

  // Request FSM, timeout counter and response capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    we_d     = we_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    off_d    = off_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    to_hit_s = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);
    case (state_q)
      S_IDLE: begin
        if (i_valid && ready_q) begin
          we_d    = i_we;
          f3_d    = i_funct3;
          addr_d  = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          off_d   = aoff_s;
          be_d    = size_be_s << aoff_s;
          wdata_d = i_wdata << {aoff_s, 3'b000};
          cnt_d   = '0;
          if (illegal_s || trap_s) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_mem_gnt) begin
          state_d = we_q ? S_RESP : S_WAIT;
        end else if (to_hit_s) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_mem_rvalid) begin
          rdata_d = load_extend(i_mem_rdata, off_q, f3_q);
          state_d = S_RESP;
        end else if (to_hit_s) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_RESP);
    req_d   = (state_d == S_REQ);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      off_q   <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_rdata     = rdata_q;
  assign o_mem_req   = req_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_we    = we_q;
  assign o_mem_be    = be_q;
  assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_klp32_lsu.sv
// Scoreboard bench for klp32_lsu: side 0 is XLEN=32 with TIMEOUT_CYC=4, side 1 is XLEN=64.
module tb_klp32_lsu;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_D = 3'b011;
  localparam logic [2:0] F_BU = 3'b100, F_HU = 3'b101, F_WU = 3'b110, F_BAD = 3'b111;

  typedef struct { logic err; bit chk_rd; logic [63:0] rdata; int cyc; } done_t;
  typedef struct { logic we; logic [31:0] addr; logic [7:0] be; logic [63:0] wdata; } mem_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  done_t dq[$];
  mem_t  mq[$];
  bit    allow [2];

  logic        rst_n    [2];
  logic        in_valid [2];
  logic        in_we    [2];
  logic [2:0]  in_f3    [2];
  logic [31:0] in_addr  [2];
  logic [63:0] in_wdata [2];
  logic        gnt      [2];
  logic        rvalid   [2];
  logic [63:0] mrdata   [2];

  wire         ready_o [2];
  wire         done_o  [2];
  wire         err_o   [2];
  wire         req_o   [2];
  wire         mwe_o   [2];
  wire [31:0]  maddr_o [2];
  wire [63:0]  rdata_o [2];
  wire [63:0]  mwd_o   [2];
  wire [7:0]   be_o    [2];
  wire [31:0]  a_rdata, a_mwd;
  wire [3:0]   a_be;

  assign rdata_o[0] = {32'h0, a_rdata};
  assign mwd_o[0]   = {32'h0, a_mwd};
  assign be_o[0]    = {4'h0, a_be};

  klp32_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(4)) dut32 (
    .clk(clk), .reset(rst_n[0]), .i_valid(in_valid[0]), .o_ready(ready_o[0]),
    .i_we(in_we[0]), .i_funct3(in_f3[0]), .i_addr(in_addr[0]), .i_wdata(in_wdata[0][31:0]),
    .o_done(done_o[0]), .o_err(err_o[0]), .o_rdata(a_rdata),
    .o_mem_req(req_o[0]), .i_mem_gnt(gnt[0]), .o_mem_addr(maddr_o[0]), .o_mem_we(mwe_o[0]),
    .o_mem_be(a_be), .o_mem_wdata(a_mwd), .i_mem_rvalid(rvalid[0]), .i_mem_rdata(mrdata[0][31:0])
  );

  klp32_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(255)) dut64 (
    .clk(clk), .reset(rst_n[1]), .i_valid(in_valid[1]), .o_ready(ready_o[1]),
    .i_we(in_we[1]), .i_funct3(in_f3[1]), .i_addr(in_addr[1]), .i_wdata(in_wdata[1]),
    .o_done(done_o[1]), .o_err(err_o[1]), .o_rdata(rdata_o[1]),
    .o_mem_req(req_o[1]), .i_mem_gnt(gnt[1]), .o_mem_addr(maddr_o[1]), .o_mem_we(mwe_o[1]),
    .o_mem_be(be_o[1]), .o_mem_wdata(mwd_o[1]), .i_mem_rvalid(rvalid[1]), .i_mem_rdata(mrdata[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop the scoreboard whenever a DUT completes or presents a memory request.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(negedge clk) begin
      done_t d;
      mem_t  m;
      if (done_o[g] === 1'b1) begin
        if (dq.size() == 0) begin
          chk("spurious_done", 64'(done_o[g]), 64'd0);
        end else begin
          d = dq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
          chk("err", 64'(err_o[g]), 64'(d.err));
          if (d.chk_rd) chk("rdata", rdata_o[g], d.rdata);
          chk("req_at_done", 64'(req_o[g]), 64'd0);
        end
      end
      if (req_o[g] === 1'b1) begin
        if (!allow[g]) begin
          chk("stray_req", 64'(req_o[g]), 64'd0);
        end else if (mq.size() > 0) begin
          m = mq[0];
          chk("mem_addr", 64'(maddr_o[g]), 64'(m.addr));
          chk("mem_be", 64'(be_o[g]), 64'(m.be));
          chk("mem_we", 64'(mwe_o[g]), 64'(m.we));
          if (m.we) chk("mem_wdata", mwd_o[g], m.wdata);
          if (gnt[g]) void'(mq.pop_front());
        end
      end
    end
  end

  task automatic wait_ready(input int s);
    int n = 0;
    while (ready_o[s] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) chk("ready_timeout", 64'(ready_o[s]), 64'd1);
  endtask

  // One request: gdly<0 never grants; mem=0 means no memory request may appear.
  task automatic op(input int s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [63:0] wd, input logic [63:0] rd, input int gdly, input bit mem,
                    input logic [31:0] eaddr, input logic [7:0] ebe, input logic [63:0] ewd,
                    input logic err, input logic [63:0] erd, input int lat);
    done_t d;
    mem_t  m;
    wait_ready(s);
    in_valid[s] = 1'b1; in_we[s] = we; in_f3[s] = f3; in_addr[s] = addr; in_wdata[s] = wd;
    allow[s] = mem;
    d = '{err: err, chk_rd: (!we && !err), rdata: erd, cyc: cyc + lat};
    dq.push_back(d);
    if (mem && gdly >= 0) begin
      m = '{we: we, addr: eaddr, be: ebe, wdata: ewd};
      mq.push_back(m);
    end
    gnt[s] = mem && (gdly == 0);
    @(posedge clk); #1;
    in_valid[s] = 1'b0;
    if (mem && gdly >= 0) begin
      for (int i = 0; i < gdly; i++) begin
        rvalid[s] = !we; mrdata[s] = ~rd;
        @(posedge clk); #1;
      end
      rvalid[s] = 1'b0; gnt[s] = 1'b1;
      @(posedge clk); #1;
      gnt[s] = 1'b0;
      if (!we) begin
        rvalid[s] = 1'b1; mrdata[s] = rd;
        @(posedge clk); #1;
        rvalid[s] = 1'b0; mrdata[s] = 64'hA5A5_A5A5_A5A5_A5A5;
      end
    end
    wait_ready(s);
    allow[s] = 1'b0;
  endtask

  // Load on the 64-bit side aborted by reset while waiting for read data.
  task automatic abort_test();
    mem_t m;
    wait_ready(1);
    in_valid[1] = 1'b1; in_we[1] = 1'b0; in_f3[1] = F_W; in_addr[1] = 32'h20;
    allow[1] = 1'b1; gnt[1] = 1'b1;
    m = '{we: 1'b0, addr: 32'h20, be: 8'h0F, wdata: 64'h0};
    mq.push_back(m);
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    gnt[1] = 1'b0; rst_n[1] = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_in_reset", 64'(ready_o[1]), 64'd0);
    chk("abort_req_in_reset", 64'(req_o[1]), 64'd0);
    chk("abort_done_in_reset", 64'(done_o[1]), 64'd0);
    rst_n[1] = 1'b1; rvalid[1] = 1'b1; mrdata[1] = 64'h1;
    @(posedge clk); #1;
    rvalid[1] = 1'b0;
    chk("abort_ready_after", 64'(ready_o[1]), 64'd1);
    allow[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; in_valid[s] = 1'b0; in_we[s] = 1'b0; in_f3[s] = 3'b000;
      in_addr[s] = 32'h0; in_wdata[s] = 64'h0; gnt[s] = 1'b0; rvalid[s] = 1'b0;
      mrdata[s] = 64'hA5A5_A5A5_A5A5_A5A5; allow[s] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_ready", 64'(ready_o[s]), 64'd0);
      chk("rst_done", 64'(done_o[s]), 64'd0);
      chk("rst_err", 64'(err_o[s]), 64'd0);
      chk("rst_req", 64'(req_o[s]), 64'd0);
      chk("rst_rdata", rdata_o[s], 64'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #1;

    // s we f3 addr wdata rdata gdly mem eaddr ebe ewdata err erdata lat
    op(0, 1, F_W,  32'h08, 64'h2,    0, 0, 1, 32'h08, 8'h0F, 64'h2,         0, 0, 2);
    op(0, 0, F_B,  32'h06, 0, 64'h0080_0000, 0, 1, 32'h04, 8'h04, 0, 0, 64'hFFFF_FF80, 3);
    op(0, 0, F_BU, 32'h06, 0, 64'h0080_0000, 0, 1, 32'h04, 8'h04, 0, 0, 64'h0000_0080, 3);
    op(0, 1, F_H,  32'h26, 64'h1234, 0, 0, 1, 32'h24, 8'h0C, 64'h1234_0000, 0, 0, 2);
    op(0, 0, F_H,  32'h26, 0, 64'h1234_0000, 0, 1, 32'h24, 8'h0C, 0, 0, 64'h0000_1234, 3);
`ifdef KLP32_LSU_MISALIGN_TRAP_EN
    op(0, 0, F_W,  32'h02, 0, 64'hDEAD_BEEF, 0, 0, 32'h0, 8'h00, 0, 1, 0, 1);
`else
    op(0, 0, F_W,  32'h02, 0, 64'hDEAD_BEEF, 0, 1, 32'h0, 8'h0F, 0, 0, 64'hDEAD_BEEF, 3);
`endif
    op(0, 1, F_W,  32'h10, 64'h55,   0, -1, 1, 32'h10, 8'h0F, 64'h55,       1, 0, 5);
    op(0, 0, F_D,  32'h08, 0, 0, 0, 0, 32'h0, 8'h00, 0, 1, 0, 1);
    op(0, 0, F_WU, 32'h08, 0, 0, 0, 0, 32'h0, 8'h00, 0, 1, 0, 1);
    op(0, 0, F_BAD, 32'h08, 0, 0, 0, 0, 32'h0, 8'h00, 0, 1, 0, 1);
    op(0, 1, F_BU, 32'h08, 64'h7, 0, 0, 0, 32'h0, 8'h00, 0, 1, 0, 1);
    op(0, 1, F_B,  32'h03, 64'hA5,   0, 2, 1, 32'h00, 8'h08, 64'hA500_0000, 0, 0, 4);
    op(0, 0, F_W,  32'h08, 0, 64'h1234_5678, 1, 1, 32'h08, 8'h0F, 0, 0, 64'h1234_5678, 4);
    op(0, 0, F_HU, 32'h02, 0, 64'h8001_0000, 0, 1, 32'h00, 8'h0C, 0, 0, 64'h0000_8001, 3);

    op(1, 0, F_D,  32'h10, 0, 64'h8000_0000_0000_0001, 0, 1, 32'h10, 8'hFF, 0, 0, 64'h8000_0000_0000_0001, 3);
    op(1, 0, F_W,  32'h14, 0, 64'h8000_0000_1234_5678, 0, 1, 32'h10, 8'hF0, 0, 0, 64'hFFFF_FFFF_8000_0000, 3);
    op(1, 0, F_WU, 32'h14, 0, 64'h8000_0000_1234_5678, 0, 1, 32'h10, 8'hF0, 0, 0, 64'h0000_0000_8000_0000, 3);
    op(1, 1, F_D,  32'h08, 64'h1122_3344_5566_7788, 0, 0, 1, 32'h08, 8'hFF, 64'h1122_3344_5566_7788, 0, 0, 2);
    op(1, 1, F_H,  32'h0E, 64'hBEEF, 0, 0, 1, 32'h08, 8'hC0, 64'hBEEF_0000_0000_0000, 0, 0, 2);
    abort_test();
    op(1, 0, F_D,  32'h10, 0, 64'h8000_0000_0000_0001, 0, 1, 32'h10, 8'hFF, 0, 0, 64'h8000_0000_0000_0001, 3);

    repeat (4) @(posedge clk);
    #1;
    if (dq.size() != 0) chk("pending_responses", 64'(dq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/klp32_lsu.md
KLP32_LSU -- requirements
Module: klp32_lsu

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter TIMEOUT_CYC, default 255, max cycles waiting on memory; 0 disables timeout.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 i_valid  input  1  core request valid.
REQ-007 o_ready  output  1  LSU idle; request accepted when i_valid and o_ready.
REQ-008 i_we  input  1  1=store, 0=load.
REQ-009 i_funct3  input  3  RISC-V size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-010 i_addr  input  ADDR_W  byte address.
REQ-011 i_wdata  input  XLEN  store data, LSB-aligned.
REQ-012 o_done  output  1  one-cycle completion pulse.
REQ-013 o_err  output  1  error flag, valid only with o_done.
REQ-014 o_rdata  output  XLEN  extended load data, valid with o_done on loads.
REQ-015 o_mem_req / i_mem_gnt  out/in  1/1  memory request handshake.
REQ-016 o_mem_addr  output  ADDR_W  address with low log2(XLEN/8) bits zero.
REQ-017 o_mem_we  output  1; o_mem_be  output  XLEN/8; o_mem_wdata  output  XLEN.
REQ-018 i_mem_rvalid / i_mem_rdata  input  1/XLEN  load return, earliest one cycle after grant.

Function
REQ-019 FSM states IDLE, REQ, WAIT, RESP; o_ready high only in IDLE.
REQ-020 IDLE: on accept, register all request fields; legal aligned -> REQ; illegal funct3 or trapped misalignment -> RESP with err.
REQ-021 Illegal funct3: 111 always; 011, 110 when XLEN=32; store funct3 >= 100.
REQ-022 REQ: o_mem_req held high with stable addr/we/be/wdata until i_mem_gnt; on grant store -> RESP, load -> WAIT.
REQ-023 WAIT: on i_mem_rvalid capture lane data -> RESP; i_mem_rvalid ignored in any other state.
REQ-024 RESP: o_done=1 for exactly one cycle, then IDLE; o_rdata held until next o_done.
REQ-025 Lane offset = addr mod XLEN/8; be = size mask (1,3,0xF,0xFF) << offset; wdata shifted left 8*offset.
REQ-026 Load: rdata shifted right 8*offset, sign-extended for b/h/w, zero-extended for bu/hu/wu, full for d.
REQ-027 Timeout counter clears on entering REQ, increments each cycle in REQ/WAIT; reaching TIMEOUT_CYC -> RESP with err, o_mem_req dropped.
REQ-028 Min latency accept->o_done: store 2 cycles, load 3 cycles, error 1 cycle.

Reset
REQ-029 While reset low: state IDLE, o_ready=0, o_done=0, o_err=0, o_mem_req=0, o_rdata=0, counter=0.
REQ-030 Reset mid-operation aborts; o_mem_req low the cycle after reset sampled; no o_done for aborted request.

Configuration
REQ-031 Macro KLP32_LSU_MISALIGN_TRAP_EN defined: access with offset not multiple of size completes with o_err=1, no memory request.
REQ-032 Macro undefined: offset rounded down to size alignment, access proceeds, misalignment never raises o_err.

Verification
REQ-033 XLEN=32, sw addr 0x8 wdata 0x2, immediate gnt -> be=0xF, mem_addr 0x8, o_done 2 cycles after accept, o_err=0.
REQ-034 lb addr 0x6, rdata 0x00800000 -> o_rdata 0xFFFFFF80; lbu same -> 0x00000080.
REQ-035 sh addr 0x26 wdata 0x1234 -> be=0xC, wdata 0x12340000; lh returns 0x00001234.
REQ-036 Macro defined, lw addr 0x2 -> o_done+o_err 1 cycle after accept, o_mem_req never high; undefined -> mem_addr 0x0, be=0xF.
REQ-037 TIMEOUT_CYC=4, gnt never asserted -> o_done+o_err, req dropped; funct3=011 at XLEN=32 -> immediate err.
REQ-038 XLEN=64, ld addr 0x10, rdata 0x8000000000000001 -> o_rdata unchanged; reset low in WAIT -> no o_done, o_ready=1 after release.
